stream_sample_scheduler: RTL

// - Paces SPI-streamed samples (register 0x10 writes) out to the DAC at a fixed sample rate.
// - Buffers bursty SPI writes in a small FIFO, primes before playback, and detects underrun/overrun.
// - Sits between the SPI register bank (sample write strobe, STREAM_MODE bit) and the output mixer/DAC.

---
 rtl/synth_pkg.sv | 10 +
 rtl/stream_fifo.sv | 53 +++++
 rtl/stream_sample_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared state encodings and constants for the streaming sample path.
package synth_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    localparam logic [7:0] MID_SCALE = 8'h80;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: DEPTH x 8 synchronous FIFO with push/pop/flush and occupancy outputs.
module stream_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign full   = r_level == (AW+1)'(DEPTH);
    assign empty  = r_level == '0;
    assign w_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rp];
    assign level  = r_level;

    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
            r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/stream_sample_scheduler.sv
// stream_sample_scheduler: buffers SPI-written samples and paces them to the DAC
// at a fixed rate, with priming, underrun and overrun detection.
module stream_sample_scheduler
    import synth_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SAMPLE_DIV  = 1042,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stream_mode,
    input  logic                       sample_wr,
    input  logic [7:0]                 sample_data,
    input  logic                       flag_clr,
    output logic [7:0]                 sample_out,
    output logic                       sample_strobe,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       playing,
    output logic                       underrun,
    output logic                       overrun
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(SAMPLE_DIV);

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [7:0]    r_sample;
    logic          r_strobe;
    logic          r_playing;
    logic          r_underrun;
    logic          r_overrun;
    logic [7:0]    w_head;
    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_tick;
    logic          w_pop;
    logic          w_wr;
    logic          w_underrun_set;
    logic          w_overrun_set;

    assign w_tick         = r_state == ST_PLAY && r_div == DW'(SAMPLE_DIV - 1);
    assign w_pop          = w_tick && !w_empty;
    // Writes only count while streaming and out of IDLE; a falling stream_mode flushes instead.
    assign w_wr           = sample_wr && stream_mode && r_state != ST_IDLE;
    assign w_underrun_set = stream_mode && w_tick && w_empty;
    assign w_overrun_set  = w_wr && w_full && !w_pop;

    stream_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr),
        .pop   (w_pop && stream_mode),
        .flush (!stream_mode),
        .din   (sample_data),
        .dout  (w_head),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_sample  <= MID_SCALE;
            r_strobe  <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (!stream_mode) begin
                r_state   <= ST_IDLE;
                r_div     <= '0;
                r_sample  <= MID_SCALE;
                r_playing <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                r_state <= ST_PRIME;
            end else if (r_state == ST_PRIME) begin
                r_div <= '0;
                if (w_level >= LW'(PRIME_LEVEL)) begin
                    r_state   <= ST_PLAY;
                    r_playing <= 1'b1;
                end
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick && w_empty) begin
                    r_state   <= ST_PRIME;
                    r_playing <= 1'b0;
                end
                if (w_pop) begin
                    r_sample <= w_head;
                    r_strobe <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= w_underrun_set ? 1'b1 : flag_clr ? 1'b0 : r_underrun;
            r_overrun  <= w_overrun_set ? 1'b1 : flag_clr ? 1'b0 : r_overrun;
        end
    end

    assign sample_out    = r_sample;
    assign sample_strobe = r_strobe;
    assign fifo_level    = w_level;
    assign playing       = r_playing;
    assign underrun      = r_underrun;
    assign overrun       = r_overrun;
endmodule
